alarm_bank: RTL
===============

Name: alarm_bank

Overview:
- Parametrised multi-channel alarm, the successor to the single-channel alarm. It compares the current hour:minute against N independently settable alarm times.
- Adds snooze with a configurable interval and a snooze-count limit, an auto-silence timeout, and per-channel enables.
- Sits beside the timekeeping counter and drives the buzzer/LED logic through ring and ring_id.
- Seconds are ignored. Time word: [10:6] = hour 0-23, [5:0] = minute 0-59.

Parameters:
- N_ALARMS, 4, number of alarm channels (1-16).
- SNOOZE_MIN, 9, minutes added per snooze (1-59).
- MAX_SNOOZE, 3, snoozes allowed per trigger; a further snooze acts as end_ring.
- RING_MAX_MIN, 5, whole-minute rollovers after which an unattended ring auto-stops (1-59).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- time_in  in  11  current {hour, minute}
- time_set_in  in  11  alarm time to load
- set_time  in  1  load time_set_in into channel set_sel this cycle
- set_sel  in  $clog2(N_ALARMS) (min 1)  channel to load
- en_in  in  N_ALARMS  per-channel enable
- end_ring  in  1  stop all ringing/snoozed channels for today
- snooze  in  1  snooze all ringing channels
- ring  out  1  OR of ring_vec
- ring_vec  out  N_ALARMS  per-channel ringing
- ring_id  out  $clog2(N_ALARMS) (min 1)  lowest-index ringing channel, 0 if none

Behaviour:
- Reset (synchronous, on clk edge with rst=1): all alarm times 00:00, all target times 00:00, all channels IDLE, snooze counts 0, ring/ring_vec/ring_id = 0.
- Per-channel registers: alarm_t, target_t (the alarm time or a snooze time), snooze_cnt, min_cnt.
- Minute tick: a single shared register holds the previous time_in; tick = time_in != previous value.
- Channel states:
  - IDLE: if en_in[i] and time_in == target_t -> RINGING; min_cnt cleared.
  - RINGING: ring_vec[i]=1, registered, asserted the cycle after the match.
  - RINGING -> DONE on end_ring, on snooze when snooze_cnt == MAX_SNOOZE, or when min_cnt reaches RING_MAX_MIN on a tick.
  - RINGING -> SNOOZED on snooze with snooze_cnt < MAX_SNOOZE: target_t = time_in + SNOOZE_MIN, snooze_cnt++.
  - SNOOZED: time_in == target_t -> RINGING, min_cnt cleared. end_ring -> DONE.
  - DONE: target_t = alarm_t, snooze_cnt = 0. Returns to IDLE once time_in != alarm_t. This gives one trigger per matching minute, and the alarm re-arms for the next day.
- Snooze arithmetic: minute sum >= 60 subtracts 60 and carries into hour; hour 24 wraps to 0. Example: 23:55 + 9 = 00:04.
- set_time for channel i: alarm_t and target_t load, snooze_cnt cleared, channel forced IDLE from any state. ring_vec[i] drops the next cycle.
- If the loaded time equals time_in, the channel rings the following cycle. Other channels are unaffected.
- en_in[i] low: channel forced IDLE; no ring while low. It may trigger on re-enable if time_in still matches.
- Simultaneous end_ring and snooze: end_ring wins.
- snooze and end_ring are level-sampled and apply to every channel in the relevant state in that cycle. Callers pulse them for one cycle.
- snooze while not RINGING is ignored.
- Channels ringing together are silenced together.
- ring_id: priority encoder over ring_vec, registered with ring_vec.
- rst mid-ring: all outputs 0 the next cycle; alarm times are lost.

Decomposition:
- Package alarm_pkg:
  - TIME_W = 11, HOUR_MSB/LSB, MIN_MSB/LSB
  - state enum {IDLE, RINGING, SNOOZED, DONE}
  - function add_minutes(time, min) with wrap
- Sub-module alarm_channel holds one channel's FSM and registers, instantiated N_ALARMS times via generate.
- The top level holds the set_sel decode, minute-tick detection, OR reduction and priority encoder.

Test Plan:
- Reset, load ch0 = 07:30, en_in = 1, sweep time_in 07:29 -> 07:30 -> ring = 1, ring_id = 0 one cycle after the match. Pulse end_ring -> ring = 0. Hold 07:30 -> no re-ring. Step to 07:31 then back to 07:30 -> rings again.
- ch1 = 23:55, ring, pulse snooze -> ring = 0. At 00:03 no ring; at 00:04 ring = 1. Snooze three more times -> the 4th snooze (MAX_SNOOZE = 3) acts as end -> DONE.
- ch2 = 06:00 ringing, no response, advance the minute to 06:05 -> ring drops on the 5th tick. No retrigger until the next 06:00.
- ch0 and ch3 both = 08:00 -> ring_vec = 4'b1001, ring_id = 0. Same-cycle snooze and end_ring -> both DONE, no snooze at 08:09.
- ch1 ringing, set_time with set_sel = 1, time_set_in = 09:00 -> ring_vec[1] = 0 next cycle, rings at 09:00.
- ch0 ringing, assert rst for one cycle -> all outputs 0. Alarm times 00:00; time_in = 00:00 with en_in = 1 -> all channels ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and time arithmetic for the multi-channel alarm bank.
// Time word layout: [10:6] hour 0-23, [5:0] minute 0-59.
package alarm_pkg;

    localparam int TIME_W   = 11;
    localparam int HOUR_MSB = 10;
    localparam int HOUR_LSB = 6;
    localparam int MIN_MSB  = 5;
    localparam int MIN_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZED,
        DONE
    } alarm_state_t;

    // Adds up to 59 minutes to a valid time word, carrying into the hour
    // and wrapping 24:00 back to 00:00.
    function automatic logic [TIME_W-1:0] add_minutes(
        input logic [TIME_W-1:0] t,
        input logic [5:0]        min
    );
        logic [6:0] m_sum;
        logic [4:0] hour;
        m_sum = {1'b0, t[MIN_MSB:MIN_LSB]} + {1'b0, min};
        hour  = t[HOUR_MSB:HOUR_LSB];
        if (m_sum >= 7'd60) begin
            m_sum = m_sum - 7'd60;
            hour  = hour + 5'd1;
        end
        if (hour >= 5'd24) begin
            hour = hour - 5'd24;
        end
        return {hour, m_sum[5:0]};
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time, snooze target and ring state machine.
//   state   | meaning
//   IDLE    | armed, waiting for time_in == target_t
//   RINGING | ringing output high, counting minute ticks
//   SNOOZED | silenced until time_in == snooze target
//   DONE    | finished for this minute; re-arms once time_in leaves alarm_t
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN   = 9,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_MAX_MIN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] time_in,
    input  logic [TIME_W-1:0] time_set_in,
    input  logic              load,
    input  logic              en,
    input  logic              tick,
    input  logic              end_ring,
    input  logic              snooze,
    output logic              ringing
);

    localparam int CNT_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam int MIN_W = $clog2(RING_MAX_MIN + 1);

    alarm_state_t      state, state_nxt;
    logic [TIME_W-1:0] alarm_t, alarm_nxt;
    logic [TIME_W-1:0] target_t, target_nxt;
    logic [CNT_W-1:0]  snooze_cnt, cnt_nxt;
    logic [MIN_W-1:0]  min_cnt, min_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alarm_t    <= '0;
            target_t   <= '0;
            snooze_cnt <= '0;
            min_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            alarm_t    <= alarm_nxt;
            target_t   <= target_nxt;
            snooze_cnt <= cnt_nxt;
            min_cnt    <= min_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        alarm_nxt  = alarm_t;
        target_nxt = target_t;
        cnt_nxt    = snooze_cnt;
        min_nxt    = min_cnt;
        if (load) begin
            alarm_nxt  = time_set_in;
            target_nxt = time_set_in;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
        end else if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (time_in == target_t) begin
                        state_nxt = RINGING;
                        min_nxt   = '0;
                    end
                end
                RINGING: begin
                    if (end_ring || (snooze && snooze_cnt == CNT_W'(MAX_SNOOZE))) begin
                        state_nxt = DONE;
                    end else if (snooze) begin
                        state_nxt  = SNOOZED;
                        target_nxt = add_minutes(time_in, 6'(SNOOZE_MIN));
                        cnt_nxt    = snooze_cnt + CNT_W'(1);
                    end else if (tick) begin
                        if ((min_cnt + MIN_W'(1)) == MIN_W'(RING_MAX_MIN)) begin
                            state_nxt = DONE;
                        end else begin
                            min_nxt = min_cnt + MIN_W'(1);
                        end
                    end
                end
                SNOOZED: begin
                    if (end_ring) begin
                        state_nxt = DONE;
                    end else if (time_in == target_t) begin
                        state_nxt = RINGING;
                        min_nxt   = '0;
                    end
                end
                DONE: begin
                    if (time_in != alarm_t) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // Re-arm to the alarm time whenever we sit in or enter DONE.
            if (state_nxt == DONE) begin
                target_nxt = alarm_t;
                cnt_nxt    = '0;
            end
        end
    end

    assign ringing = (state == RINGING);

endmodule

// File: rtl/alarm_bank.sv
// N-channel alarm bank: channel load decode, shared minute tick, ring
// OR-reduction and lowest-index ring_id encoder.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARMS     = 4,
    parameter int SNOOZE_MIN   = 9,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_MAX_MIN = 5,
    localparam int SEL_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TIME_W-1:0]   time_in,
    input  logic [TIME_W-1:0]   time_set_in,
    input  logic                set_time,
    input  logic [SEL_W-1:0]    set_sel,
    input  logic [N_ALARMS-1:0] en_in,
    input  logic                end_ring,
    input  logic                snooze,
    output logic                ring,
    output logic [N_ALARMS-1:0] ring_vec,
    output logic [SEL_W-1:0]    ring_id
);

    logic [TIME_W-1:0] prev_time;
    logic              tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_time <= '0;
        end else begin
            prev_time <= time_in;
        end
    end

    assign tick = (time_in != prev_time);

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .SNOOZE_MIN  (SNOOZE_MIN),
            .MAX_SNOOZE  (MAX_SNOOZE),
            .RING_MAX_MIN(RING_MAX_MIN)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .time_in    (time_in),
            .time_set_in(time_set_in),
            .load       (set_time && (set_sel == SEL_W'(i))),
            .en         (en_in[i]),
            .tick       (tick),
            .end_ring   (end_ring),
            .snooze     (snooze),
            .ringing    (ring_vec[i])
        );
    end

    // ring_vec comes straight from channel state flops, so ring_id is
    // aligned with it without an extra register stage.
    always_comb begin
        ring_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (ring_vec[i]) begin
                ring_id = SEL_W'(i);
            end
        end
    end

    assign ring = |ring_vec;

endmodule
